// File: rtl/dmem_ldst_slave_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ldst_slave_pkg
// Shared types for the load/store channel between the execution unit and the
// data-memory responder:
//   RV_XLEN        - architectural register/address width
//   ldst_size_t    - access size encoding (byte / half / word / illegal)
//   ldst_req_t     - request packet (addr, we, size, sext, wdata)
//   ldst_rsp_t     - response packet (rdata, err)
//   ldst_align_off - byte offset actually used for an access of a given size
// -----------------------------------------------------------------------------
package dmem_ldst_slave_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [1:0] {
    LDST_SIZE_B    = 2'd0,
    LDST_SIZE_H    = 2'd1,
    LDST_SIZE_W    = 2'd2,
    LDST_SIZE_RSVD = 2'd3
  } ldst_size_t;

  typedef struct packed {
    logic [RV_XLEN-1:0] addr;
    logic               we;
    ldst_size_t         size;
    logic               sext;
    logic [RV_XLEN-1:0] wdata;
  } ldst_req_t;

  typedef struct packed {
    logic [RV_XLEN-1:0] rdata;
    logic               err;
  } ldst_rsp_t;

  // Misaligned halves/words are steered to their aligned-down location. When
  // the misalignment check is enabled such accesses fault before reaching the
  // SRAM, so the same alignment is correct for both builds.
  function automatic logic [1:0] ldst_align_off(input ldst_size_t size,
                                                input logic [1:0] off);
    logic [1:0] res;
    case (size)
      LDST_SIZE_B: res = off;
      LDST_SIZE_H: res = {off[1], 1'b0};
      default:     res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ldst_slave_if.sv
// -----------------------------------------------------------------------------
// ldst_if_t
// Load/store request/response channel.
//   req_vld/req_rdy/req_pkt : request handshake, master -> slave
//   rsp_vld/rsp_rdy/rsp_pkt : response handshake, slave -> master
// Modports: master (execution unit side), slave (memory responder side).
// -----------------------------------------------------------------------------
interface ldst_if_t;
  import dmem_ldst_slave_pkg::*;

  logic      req_vld;
  logic      req_rdy;
  ldst_req_t req_pkt;
  logic      rsp_vld;
  logic      rsp_rdy;
  ldst_rsp_t rsp_pkt;

  modport master (
    output req_vld, req_pkt, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_pkt
  );

  modport slave (
    input  req_vld, req_pkt, rsp_rdy,
    output req_rdy, rsp_vld, rsp_pkt
  );
endinterface

// File: rtl/dmem_ldst_slave_lane_align.sv
// -----------------------------------------------------------------------------
// ldst_lane_align
// Purely combinational byte-lane steering shared by the store and load paths.
//   size, off, sext : access size, effective byte offset, sign-extend flag
//   wdata           : right-aligned store data
//   rdata           : raw 32-bit SRAM word
//   be              : SRAM byte enables for a store
//   wdata_lane      : store data replicated across all lanes
//   rdata_ext       : load data extracted from the lane and extended
// -----------------------------------------------------------------------------
module ldst_lane_align
  import dmem_ldst_slave_pkg::*;
(
  input  ldst_size_t  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = shifted;
    case (size)
      LDST_SIZE_B: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      LDST_SIZE_H: begin
        be         = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ldst_slave.sv
// -----------------------------------------------------------------------------
// dmem_ldst_slave
// Responder end of the load/store channel. Accepts one request at a time,
// performs it on a single-port synchronous 32-bit SRAM and returns a response
// with load data or an access-fault flag.
//   clk, rst_n  : clock, synchronous active-low reset
//   ldst_dst    : ldst_if_t.slave request/response channel
//   sram_cs/we  : SRAM chip select / write enable (only in a good handshake)
//   sram_be     : byte enables
//   sram_addr   : word address
//   sram_wdata  : lane-replicated write data
//   sram_rdata  : read data, valid the cycle after a read select
// Build option: define DMEM_MISALIGN_CHK_EN to fault misaligned half/word
// accesses; otherwise they proceed to the aligned-down location.
// Latency: store/fault response one cycle after the handshake, load two.
// -----------------------------------------------------------------------------
module dmem_ldst_slave
  import dmem_ldst_slave_pkg::*;
#(
  parameter int DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  ldst_if_t.slave            ldst_dst,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [DMEM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state, state_next;
  ldst_req_t  req;

  logic       req_rdy;
  logic       hs;
  logic       out_of_range;
  logic       misalign;
  logic       fault;
  logic [1:0] req_off;

  // Load context captured at the handshake, consumed in RD.
  logic [1:0] ld_off;
  ldst_size_t ld_size;
  logic       ld_sext;

  // Shared lane aligner inputs/outputs.
  ldst_size_t  la_size;
  logic [1:0]  la_off;
  logic        la_sext;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;

  logic       rsp_vld_q;
  ldst_rsp_t  rsp_q;

  assign req = ldst_dst.req_pkt;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign out_of_range = |req.addr[RV_XLEN-1:DMEM_AW+2];
  assign req_off      = ldst_align_off(req.size, req.addr[1:0]);

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = ((req.size == LDST_SIZE_H) && req.addr[0]) ||
                    ((req.size == LDST_SIZE_W) && (req.addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault = out_of_range || (req.size == LDST_SIZE_RSVD) || misalign;
  assign hs    = ldst_dst.req_vld && (state == S_IDLE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of block ordering.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (ldst_dst.req_vld) state_next = (fault || req.we) ? S_RESP : S_RD;
      S_RD:   state_next = S_RESP;
      S_RESP: if (ldst_dst.rsp_rdy) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (request ready and SRAM controls)
  // ---------------------------------------------------------------------------
  always_comb begin
    req_rdy    = (state == S_IDLE);
    sram_cs    = hs && !fault;
    sram_we    = hs && !fault && req.we;
    sram_be    = sram_cs ? la_be : 4'b0000;
    sram_addr  = req.addr[DMEM_AW+1:2];
    sram_wdata = sram_we ? la_wdata : 32'd0;
  end

  // The aligner serves the store path in IDLE and the load path in RD.
  always_comb begin
    la_size = req.size;
    la_off  = req_off;
    la_sext = req.sext;
    if (state == S_RD) begin
      la_size = ld_size;
      la_off  = ld_off;
      la_sext = ld_sext;
    end
  end

  ldst_lane_align u_lane_align (
    .size       (la_size),
    .off        (la_off),
    .sext       (la_sext),
    .wdata      (req.wdata[31:0]),
    .rdata      (sram_rdata),
    .be         (la_be),
    .wdata_lane (la_wdata),
    .rdata_ext  (la_rdata)
  );

  // ---------------------------------------------------------------------------
  // Response and load-context registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are reset too, because the response
    // packet is architecturally visible and must read as zero out of reset.
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
      ld_off    <= 2'b00;
      ld_size   <= LDST_SIZE_B;
      ld_sext   <= 1'b0;
    end else begin
      rsp_vld_q <= (state_next == S_RESP);
      case (state)
        S_IDLE: begin
          if (hs) begin
            if (fault) begin
              rsp_q.err   <= 1'b1;
              rsp_q.rdata <= '0;
            end else if (req.we) begin
              rsp_q.err   <= 1'b0;
              rsp_q.rdata <= '0;
            end else begin
              ld_off  <= req_off;
              ld_size <= req.size;
              ld_sext <= req.sext;
            end
          end
        end
        S_RD: begin
          rsp_q.err   <= 1'b0;
          rsp_q.rdata <= la_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ldst_dst.req_rdy = req_rdy;
  assign ldst_dst.rsp_vld = rsp_vld_q;
  assign ldst_dst.rsp_pkt = rsp_q;

endmodule

// File: tb/tb_dmem_ldst_slave.sv
// -----------------------------------------------------------------------------
// tb_dmem_ldst_slave
// Self-checking bench for dmem_ldst_slave: a behavioural SRAM macro, a
// byte-addressed reference memory, directed scenarios and random traffic.
// Honours DMEM_MISALIGN_CHK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_ldst_slave;
  import dmem_ldst_slave_pkg::*;

  localparam int AW     = 10;
  localparam int NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sram_cs, sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [3:0]  last_be;
  logic        last_err;
  logic [31:0] got;

  ldst_if_t bus ();

  dmem_ldst_slave #(.DMEM_AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ldst_dst   (bus),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro.
  logic [31:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference memory, one entry per byte.
  logic [7:0] ref_mem [0:NBYTES-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // The SRAM may only be selected in a request handshake cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n)
      check("cs_only_on_hs", 32'(sram_cs && !(bus.req_vld && bus.req_rdy)), 32'd0);
  end

  // Reference model of one access: fault decision, expected byte enables and
  // lane data for stores, expected load result; updates ref_mem on stores.
  function automatic void model(input logic [31:0] addr, input logic we,
                                input logic [1:0] size, input logic sext,
                                input logic [31:0] wdata,
                                output logic fault, output logic [31:0] rdata,
                                output logic [3:0] be, output logic [31:0] lane);
    int unsigned n, base, lo;
    logic mis;
    n     = 32'd1 << size;
    mis   = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    mis   = (size != 2'd3) && ((addr % n) != 0);
`endif
    fault = (addr >= NBYTES) || (size == 2'd3) || mis;
    rdata = 32'd0;
    be    = 4'd0;
    lane  = 32'd0;
    if (fault) return;
    base = addr - (addr % n);
    lo   = base % 4;
    for (int unsigned i = 0; i < n; i++) begin
      be[lo+i]          = 1'b1;
      lane[8*(lo+i)+:8] = wdata[8*i +: 8];
      if (we) ref_mem[base+i] = wdata[8*i +: 8];
      else    rdata[8*i +: 8] = ref_mem[base+i];
    end
    if (!we && sext && rdata[8*n-1])
      for (int unsigned i = 8*n; i < 32; i++) rdata[i] = 1'b1;
  endfunction

  task automatic access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic sext, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata_out);
    logic        fault;
    logic [31:0] exp_rdata, exp_lane, mask, held_rdata;
    logic [3:0]  exp_be;
    logic        held_err;
    int          n;
    model(addr, we, size, sext, wdata, fault, exp_rdata, exp_be, exp_lane);
    @(negedge clk);
    bus.req_vld       = 1'b1;
    bus.req_pkt.addr  = addr;
    bus.req_pkt.we    = we;
    bus.req_pkt.size  = ldst_size_t'(size);
    bus.req_pkt.sext  = sext;
    bus.req_pkt.wdata = wdata;
    bus.rsp_rdy       = (hold == 0);
    #1;
    n = 0;
    while (!bus.req_rdy && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("req_rdy", 32'(bus.req_rdy), 32'd1);
    check("sram_cs", 32'(sram_cs), 32'(!fault));
    last_be = sram_be;
    if (!fault) begin
      check("sram_we", 32'(sram_we), 32'(we));
      check("sram_addr", 32'(sram_addr), 32'(addr[AW+1:2]));
      if (we) begin
        check("sram_be", 32'(sram_be), 32'(exp_be));
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{exp_be[b]}};
        check("sram_wdata", sram_wdata & mask, exp_lane);
      end
    end
    @(negedge clk);
    bus.req_vld = 1'b0;
    #1;
    n = 1;
    while (!bus.rsp_vld && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("rsp_latency", 32'(n), (we || fault) ? 32'd1 : 32'd2);
    held_rdata = bus.rsp_pkt.rdata;
    held_err   = bus.rsp_pkt.err;
    for (int h = 0; h < hold; h++) begin
      check("hold_vld", 32'(bus.rsp_vld), 32'd1);
      check("hold_rdata", bus.rsp_pkt.rdata, held_rdata);
      check("hold_err", 32'(bus.rsp_pkt.err), 32'(held_err));
      check("hold_req_rdy", 32'(bus.req_rdy), 32'd0);
      @(negedge clk); #1;
    end
    bus.rsp_rdy = 1'b1;
    check("rsp_err", 32'(bus.rsp_pkt.err), 32'(fault));
    check("rsp_rdata", bus.rsp_pkt.rdata, exp_rdata);
    rdata_out = bus.rsp_pkt.rdata;
    last_err  = bus.rsp_pkt.err;
    @(negedge clk); #1;
    check("post_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("post_req_rdy", 32'(bus.req_rdy), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        we, sx;

    bus.req_vld = 1'b0;
    bus.req_pkt = '0;
    bus.rsp_rdy = 1'b0;
    for (int w = 0; w < (1 << AW); w++) begin
      sram_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = sram_mem[w][8*b +: 8];
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("rst_rsp_rdata", bus.rsp_pkt.rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_pkt.err), 32'd0);
    check("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    check("rst_sram_cs", 32'(sram_cs), 32'd0);
    rst_n = 1'b1;

    // Word store then word load.
    access(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0, got);
    access(32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 0, got);
    check("ld_word", got, 32'hDEADBEEF);

    // Byte store to the top lane, then signed and unsigned byte loads.
    access(32'h13, 1'b1, 2'd0, 1'b0, 32'h00000080, 0, got);
    check("st_byte_be", 32'(last_be), 32'h8);
    access(32'h13, 1'b0, 2'd0, 1'b1, 32'd0, 0, got);
    check("ld_byte_sext", got, 32'hFFFFFF80);
    access(32'h13, 1'b0, 2'd0, 1'b0, 32'd0, 0, got);
    check("ld_byte_zext", got, 32'h00000080);

    // Out-of-range load.
    access(32'd1 << (AW + 2), 1'b0, 2'd2, 1'b0, 32'd0, 0, got);
    check("oor_err", 32'(last_err), 32'd1);
    check("oor_rdata", got, 32'd0);

    // Misaligned half load.
    access(32'h11, 1'b0, 2'd1, 1'b0, 32'd0, 0, got);
`ifdef DMEM_MISALIGN_CHK_EN
    check("half_mis_err", 32'(last_err), 32'd1);
`else
    check("half_mis_data", got, 32'h0000BEEF);
`endif

    // Response back-pressure for five cycles.
    access(32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 5, got);
    check("hold_ld_word", got, 32'h80ADBEEF);

    // Reset while the load is in RD.
    @(negedge clk);
    bus.req_vld       = 1'b1;
    bus.req_pkt.addr  = 32'h10;
    bus.req_pkt.we    = 1'b0;
    bus.req_pkt.size  = LDST_SIZE_W;
    bus.req_pkt.sext  = 1'b0;
    bus.rsp_rdy       = 1'b1;
    #1;
    check("rd_rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    @(negedge clk);
    bus.req_vld = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    #1;
    check("rd_rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("rd_rst_req_rdy_after", 32'(bus.req_rdy), 32'd1);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      check("rd_rst_no_rsp", 32'(bus.rsp_vld), 32'd0);
    end

    // Random traffic against the reference model.
    for (int k = 0; k < 250; k++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63))
                                      : 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 11) == 0) a = $urandom | 32'h0000_1000;
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sx = 1'($urandom_range(0, 1));
      wd = $urandom;
      access(a, we, sz, sx, wd, $urandom_range(0, 2), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
